// File: rtl/alu_arb_pkg.sv
// Package: alu_arb_pkg
// Shared definitions for the ALU share arbiter: FSM state encoding,
// owner encoding and operand-B select codes.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_IMM  = 2'b01;
  localparam logic [1:0] SEL_ZIMM = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

endpackage

// File: rtl/alu_arb_prio.sv
// Module: alu_arb_prio
// Combinational grant pick between CPU and DMA, with an optional starvation
// counter that forces a DMA win after STARVE_MAX CPU wins over a pending DMA
// request.
// Configuration macro: ALU_ARB_STARVE_GUARD_EN (undefined = strict CPU priority,
// no counter).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (counter only)
//   cpu_req, dma_req   pending requests
//   arb_en             arbitration window open (a grant is taken this cycle)
//   cpu_pick, dma_pick one-hot (or zero) winner
module alu_arb_prio #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic arb_en,
  output logic cpu_pick,
  output logic dma_pick
);

`ifdef ALU_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve_hit;

  assign starve_hit = (cnt_q == CW'(STARVE_MAX));
  assign dma_pick   = dma_req & (~cpu_req | starve_hit);
  assign cpu_pick   = cpu_req & ~dma_pick;

  // Count only CPU wins taken while DMA was waiting; a DMA win resets it.
  always_comb begin
    cnt_d = cnt_q;
    if (arb_en) begin
      if (dma_pick) begin
        cnt_d = '0;
      end else if (cpu_pick && dma_req) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign cpu_pick   = cpu_req;
  assign dma_pick   = dma_req & ~cpu_req;
  assign unused_cfg = ^{clk, rst_n, arb_en, STARVE_MAX[0]};
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Module: alu_share_arbiter
// Shares one ALU and its operand-B mux between the CPU execute stage and the
// DMA engine. The winner's operands and select are registered at grant, drive
// the ALU for one cycle (EXEC), the result is captured and returned with a
// done pulse to the owner (RESP). A new grant may overlap the RESP cycle.
// Configuration macro: ALU_ARB_STARVE_GUARD_EN (starvation guard in alu_arb_prio).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpu_req/sel/a/b/imm/zimm        CPU request + operands (held until cpu_gnt)
//   cpu_gnt, cpu_done               CPU accept / result-valid pulses
//   dma_*                           same set for DMA
//   alu_sel/a/b/imm/zimm            registered operands to ALU and B mux
//   alu_result                      combinational ALU output
//   rsp_result                      captured result (shared)
//   busy                            high in EXEC and RESP
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [1:0]    cpu_sel,
  input  logic [DW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_b,
  input  logic [DW-1:0] cpu_imm,
  input  logic [DW-1:0] cpu_zimm,
  output logic          cpu_gnt,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic [1:0]    dma_sel,
  input  logic [DW-1:0] dma_a,
  input  logic [DW-1:0] dma_b,
  input  logic [DW-1:0] dma_imm,
  input  logic [DW-1:0] dma_zimm,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [1:0]    alu_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] alu_imm,
  output logic [DW-1:0] alu_zimm,
  input  logic [DW-1:0] alu_result,
  output logic [DW-1:0] rsp_result,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [1:0]    alu_sel_q, alu_sel_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [DW-1:0] alu_imm_q, alu_imm_d;
  logic [DW-1:0] alu_zimm_q, alu_zimm_d;
  logic [DW-1:0] rsp_result_q, rsp_result_d;

  logic arb_en, cpu_pick, dma_pick, cpu_take, dma_take;

  // Arbitration only in IDLE/RESP; gating with rst_n keeps gnt low during reset.
  assign arb_en   = rst_n && (state_q != ST_EXEC);
  assign cpu_take = arb_en & cpu_pick;
  assign dma_take = arb_en & dma_pick;

  alu_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .arb_en   (arb_en),
    .cpu_pick (cpu_pick),
    .dma_pick (dma_pick)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    alu_sel_d    = alu_sel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_imm_d    = alu_imm_q;
    alu_zimm_d   = alu_zimm_q;
    rsp_result_d = rsp_result_q;

    case (state_q)
      ST_IDLE: if (cpu_take || dma_take) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d      = ST_RESP;
        rsp_result_d = alu_result;
      end
      ST_RESP: state_d = (cpu_take || dma_take) ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (dma_take) begin
      owner_d    = OWN_DMA;
      alu_sel_d  = dma_sel;
      alu_a_d    = dma_a;
      alu_b_d    = dma_b;
      alu_imm_d  = dma_imm;
      alu_zimm_d = dma_zimm;
    end else if (cpu_take) begin
      owner_d    = OWN_CPU;
      alu_sel_d  = cpu_sel;
      alu_a_d    = cpu_a;
      alu_b_d    = cpu_b;
      alu_imm_d  = cpu_imm;
      alu_zimm_d = cpu_zimm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      alu_sel_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_imm_q    <= '0;
      alu_zimm_q   <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      alu_sel_q    <= alu_sel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_imm_q    <= alu_imm_d;
      alu_zimm_q   <= alu_zimm_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign cpu_gnt    = cpu_take;
  assign dma_gnt    = dma_take;
  assign cpu_done   = rst_n && (state_q == ST_RESP) && (owner_q == OWN_CPU);
  assign dma_done   = rst_n && (state_q == ST_RESP) && (owner_q == OWN_DMA);
  assign busy       = rst_n && ((state_q == ST_EXEC) || (state_q == ST_RESP));
  assign alu_sel    = alu_sel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_imm    = alu_imm_q;
  assign alu_zimm   = alu_zimm_q;
  assign rsp_result = rsp_result_q;

endmodule
